// File: rtl/alu_exec_if.sv
// -----------------------------------------------------------------------------
// alu_exec_if -- request/response bundle for the alu_exec execute stage.
//
// Request side  : in_valid/in_ready handshake carrying alu_op, funct and the
//                 two operands src_a/src_b.
// Response side : out_valid/out_ready handshake carrying result, zero and err.
//
// Modports:
//   master -- the requester/consumer (drives requests, takes results)
//   slave  -- the ALU itself
// -----------------------------------------------------------------------------
interface alu_exec_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       alu_op;
   logic [5:0]       funct;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             err;

   modport master (
      output in_valid, alu_op, funct, src_a, src_b, out_ready,
      input  in_ready, out_valid, result, zero, err
   );

   modport slave (
      input  in_valid, alu_op, funct, src_a, src_b, out_ready,
      output in_ready, out_valid, result, zero, err
   );
endinterface

// File: rtl/alu_exec.sv
// -----------------------------------------------------------------------------
// alu_exec -- execute-stage ALU with valid/ready handshakes on both sides.
//
// Ports:
//   clk  -- single clock, all state changes on the rising edge
//   rst  -- synchronous, active-high reset
//   bus  -- alu_exec_if.slave: request (in_valid/in_ready, alu_op, funct,
//           src_a, src_b) and response (out_valid/out_ready, result, zero, err)
//
// Operation classes (alu_op): 00 add, 01 A-B, 10 R-type selected by funct,
// 11 reserved (computes add but flags err). Single-cycle ops present their
// result the cycle after accept and sit in HOLD until the consumer takes it.
//
// Optional feature macro: ALU_EXEC_MUL_EN
//   defined   -- funct 000111 runs an unsigned shift-add multiply, one
//                multiplier bit per cycle, WIDTH cycles in the MUL state.
//   undefined -- no MUL state, no multiply registers; funct 000111 is an
//                undecoded function (result 0, err 1).
// -----------------------------------------------------------------------------
module alu_exec #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic      clk,
   input logic      rst,
   alu_exec_if.slave bus
);

   // Elaboration-time sanity check of the parameter set.
   generate
      if (WIDTH < 4 || WIDTH > 64 || (2 ** CNT_W) <= WIDTH) begin : g_param_check
         $error("alu_exec: WIDTH must be 4..64 and 2**CNT_W must exceed WIDTH");
      end
   endgenerate

   localparam logic [5:0] F_ADD = 6'b000000;
   localparam logic [5:0] F_SUB = 6'b000001;
   localparam logic [5:0] F_SLT = 6'b000010;
   localparam logic [5:0] F_AND = 6'b000011;
   localparam logic [5:0] F_OR  = 6'b000100;
   localparam logic [5:0] F_XOR = 6'b000101;
   localparam logic [5:0] F_NOR = 6'b000110;
   localparam logic [5:0] F_MUL = 6'b000111;

`ifdef ALU_EXEC_MUL_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      HOLD = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd2
   } state_t;
`endif

   state_t           state_q;
   state_t           state_d;
   state_t           accept_state;
   logic [WIDTH-1:0] result_q;
   logic             err_q;
   logic [WIDTH-1:0] op_res;
   logic             op_err;
   logic             accept;

`ifdef ALU_EXEC_MUL_EN
   logic             op_mul;
   logic [WIDTH-1:0] mul_a_q;     // multiplicand, shifted left each step
   logic [WIDTH-1:0] mul_b_q;     // multiplier, shifted right each step
   logic [WIDTH-1:0] mul_acc_q;   // running partial product
   logic [CNT_W-1:0] mul_cnt_q;   // steps already taken
   logic [WIDTH-1:0] mul_sum;
   logic             mul_last;

   assign mul_sum  = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);
   assign mul_last = (mul_cnt_q == CNT_W'(WIDTH - 1));
`endif

   // Reset wins over everything, so no request can slip in while rst is high.
   assign bus.in_ready  = !rst && ((state_q == IDLE) ||
                                   ((state_q == HOLD) && bus.out_ready));
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = (state_q == HOLD);
   assign bus.result    = result_q;
   assign bus.zero      = (result_q == '0);
   assign bus.err       = err_q;

   // -------------------------------------------------------------------------
   // Request decode (single-cycle result, error flag, state after accept)
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // that no path through the case statements leaves it unassigned, which
      // would otherwise infer a latch.
      op_res       = '0;
      op_err       = 1'b0;
      accept_state = HOLD;
`ifdef ALU_EXEC_MUL_EN
      op_mul       = 1'b0;
`endif
      case (bus.alu_op)
         2'b00: op_res = bus.src_a + bus.src_b;
         2'b01: op_res = bus.src_a - bus.src_b;
         2'b10: begin
            case (bus.funct)
               F_ADD: op_res = bus.src_a + bus.src_b;
               F_SUB: op_res = bus.src_a - bus.src_b;
               F_SLT: op_res = ($signed(bus.src_a) < $signed(bus.src_b)) ? WIDTH'(1) : '0;
               F_AND: op_res = bus.src_a & bus.src_b;
               F_OR:  op_res = bus.src_a | bus.src_b;
               F_XOR: op_res = bus.src_a ^ bus.src_b;
               F_NOR: op_res = ~(bus.src_a | bus.src_b);
`ifdef ALU_EXEC_MUL_EN
               F_MUL: begin
                  op_mul       = 1'b1;
                  accept_state = MUL;
               end
`endif
               default: op_err = 1'b1;   // undecoded: result stays 0
            endcase
         end
         default: begin
            // Reserved class still produces the sum so downstream sees a
            // deterministic value, but the request is flagged.
            op_res = bus.src_a + bus.src_b;
            op_err = 1'b1;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = accept_state;
`ifdef ALU_EXEC_MUL_EN
         MUL:  if (mul_last) state_d = HOLD;
`endif
         HOLD: begin
            if (bus.out_ready) state_d = accept ? accept_state : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // State, result and multiplier registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q   <= IDLE;
         result_q  <= '0;
         err_q     <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
         mul_a_q   <= '0;
         mul_b_q   <= '0;
         mul_acc_q <= '0;
         mul_cnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;

         if (accept) begin
`ifdef ALU_EXEC_MUL_EN
            if (op_mul) begin
               // Operands are captured here; later input changes are ignored.
               mul_a_q   <= bus.src_a;
               mul_b_q   <= bus.src_b;
               mul_acc_q <= '0;
               mul_cnt_q <= '0;
               err_q     <= 1'b0;
            end else begin
               result_q <= op_res;
               err_q    <= op_err;
            end
`else
            result_q <= op_res;
            err_q    <= op_err;
`endif
         end

`ifdef ALU_EXEC_MUL_EN
         // accept and MUL are mutually exclusive: in_ready is low in MUL.
         if (state_q == MUL) begin
            mul_acc_q <= mul_sum;
            mul_a_q   <= mul_a_q << 1;
            mul_b_q   <= mul_b_q >> 1;
            mul_cnt_q <= mul_cnt_q + CNT_W'(1);
            if (mul_last) result_q <= mul_sum;
         end
`endif
      end
   end

endmodule

// File: tb/tb_alu_exec.sv
// -----------------------------------------------------------------------------
// tb_alu_exec -- directed-vector bench for alu_exec (WIDTH = 32).
// Stimulus pushes the hand-computed expected response into a scoreboard queue
// at the moment a request is accepted; an independent monitor pops and compares
// whenever the DUT hands over a result (out_valid && out_ready).
// Multiply expectations follow ALU_EXEC_MUL_EN.
// -----------------------------------------------------------------------------
module tb_alu_exec;
   localparam int WIDTH = 32;
`ifdef ALU_EXEC_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             err;
      string            name;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   alu_exec_if #(.WIDTH(WIDTH)) bus ();

   alu_exec #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   exp_t sb[$];
   int   out_cyc[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   n_out  = 0;
   exp_t mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: one pop per result handed over.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got result 0x%0h, no result expected", bus.result);
            end else begin
               mon_e = sb.pop_front();
               check({mon_e.name, "_result"}, 64'(bus.result), 64'(mon_e.res));
               check({mon_e.name, "_err"},    64'(bus.err),    64'(mon_e.err));
               check({mon_e.name, "_zero"},   64'(bus.zero),   64'(mon_e.res == '0));
            end
            out_cyc.push_back(cyc);
            n_out++;
         end
      end
   end

   // Present a request until accepted; the expectation is queued on acceptance.
   task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_res, input logic exp_err,
                        input string name, output int acc_cyc, output int waits);
      exp_t e;
      bit   done;
      bus.in_valid = 1'b1;
      bus.alu_op   = op;
      bus.funct    = fn;
      bus.src_a    = a;
      bus.src_b    = b;
      waits        = 0;
      acc_cyc      = -1;
      done         = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) begin
            e.res   = exp_res;
            e.err   = exp_err;
            e.name  = name;
            sb.push_back(e);
            acc_cyc = cyc;
            done    = 1'b1;
         end else begin
            waits++;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s_accept: got no accept in 100 cycles, expected in_ready", name);
      end
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Global safety net.
   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a0, a1, w, wsum, n0, lat;

      rst           = 1'b1;
      bus.in_valid  = 1'b1;          // request pending during reset must be refused
      bus.alu_op    = 2'b00;
      bus.funct     = 6'b0;
      bus.src_a     = 32'd1;
      bus.src_b     = 32'd1;
      bus.out_ready = 1'b1;

      // ---- reset state ------------------------------------------------------
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready",  64'(bus.in_ready),  64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_result",    64'(bus.result),    64'd0);
      check("rst_zero",      64'(bus.zero),      64'd1);
      check("rst_err",       64'(bus.err),       64'd0);
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("idle_in_ready",  64'(bus.in_ready),  64'd1);
      check("idle_out_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;

      // ---- latency 1 and release of HOLD ------------------------------------
      issue(2'b00, 6'h00, 32'd5, 32'd7, 32'd12, 1'b0, "add_5_7", a0, w);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("add_latency_valid", 64'(bus.out_valid), 64'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("hold_release_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;

      issue(2'b01, 6'h00, 32'd9,          32'd9, 32'd0, 1'b0, "sub_9_9",  a0, w);
      issue(2'b10, 6'h02, 32'hFFFF_FFFF,  32'd1, 32'd1, 1'b0, "slt_neg1", a0, w);
      idle(2);

      // ---- back-to-back single-cycle ops -------------------------------------
      n0   = n_out;
      wsum = 0;
      issue(2'b10, 6'h00, 32'd1,    32'd1,    32'd2,          1'b0, "b2b_add", a0, w); wsum += w;
      issue(2'b10, 6'h01, 32'd3,    32'd5,    32'hFFFF_FFFE,  1'b0, "b2b_sub", a0, w); wsum += w;
      issue(2'b10, 6'h03, 32'hF0,   32'h3C,   32'h30,         1'b0, "b2b_and", a0, w); wsum += w;
      issue(2'b10, 6'h06, 32'd0,    32'd0,    32'hFFFF_FFFF,  1'b0, "b2b_nor", a0, w); wsum += w;
      idle(3);
      check("b2b_stall_cycles", 64'(wsum), 64'd0);
      check("b2b_output_count", 64'(n_out - n0), 64'd4);
      lat = (out_cyc.size() >= n0 + 4) ? out_cyc[n0 + 3] - out_cyc[n0] : -1;
      check("b2b_output_span", 64'(lat), 64'd3);

      // ---- illegal requests and err clearing ---------------------------------
      issue(2'b10, 6'h3F, 32'd8, 32'd9, 32'd0, 1'b1, "funct_3f",      a0, w);
      issue(2'b00, 6'h00, 32'd2, 32'd3, 32'd5, 1'b0, "add_err_clear", a0, w);
      issue(2'b11, 6'h00, 32'd4, 32'd4, 32'd8, 1'b1, "op_reserved",   a0, w);
      issue(2'b10, 6'h04, 32'hA0, 32'h05, 32'hA5, 1'b0, "or_a0_05",   a0, w);
      idle(2);

      // ---- consumer stall in HOLD --------------------------------------------
      bus.out_ready = 1'b0;
      issue(2'b10, 6'h05, 32'h0F0F, 32'h00FF, 32'h0FF0, 1'b0, "xor_hold", a0, w);
      bus.in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_out_valid", 64'(bus.out_valid), 64'd1);
         check("stall_result",    64'(bus.result),    64'h0FF0);
         check("stall_in_ready",  64'(bus.in_ready),  64'd0);
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      idle(2);

      // ---- multiply (operands changed while busy) -----------------------------
      n0 = n_out;
      issue(2'b10, 6'h07, 32'h0001_0001, 32'h0001_0001,
            MUL_EN ? 32'h0002_0001 : 32'd0, MUL_EN ? 1'b0 : 1'b1, "mul", a0, w);
      issue(2'b00, 6'h00, 32'd100, 32'd200, 32'd300, 1'b0, "add_after_mul", a1, w);
      idle(3);
      check("mul_in_ready_low_cycles", 64'(w), MUL_EN ? 64'd32 : 64'd0);
      check("mul_output_count", 64'(n_out - n0), 64'd2);
      lat = (out_cyc.size() > n0) ? out_cyc[n0] - a0 : -1;
      check("mul_latency", 64'(lat), MUL_EN ? 64'd33 : 64'd1);

      // ---- reset in the middle of a multiply ----------------------------------
      n0 = n_out;
      issue(2'b10, 6'h07, 32'h0001_0001, 32'h0001_0001,
            MUL_EN ? 32'h0002_0001 : 32'd0, MUL_EN ? 1'b0 : 1'b1, "mul_rst", a0, w);
      bus.in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();                   // the aborted multiply is never delivered
      @(negedge clk);
      check("mulrst_in_ready",  64'(bus.in_ready),  64'd1);
      check("mulrst_out_valid", 64'(bus.out_valid), 64'd0);
      check("mulrst_result",    64'(bus.result),    64'd0);
      check("mulrst_zero",      64'(bus.zero),      64'd1);
      check("mulrst_err",       64'(bus.err),       64'd0);
      idle(40);
      check("mulrst_output_count", 64'(n_out - n0), MUL_EN ? 64'd0 : 64'd1);

      check("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal range 4..64.
REQ-002 Parameter CNT_W, default 6, multiply-step counter width; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  request present on alu_op/funct/src_a/src_b.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 alu_op  input  2  class: 00 load/store add, 01 branch subtract, 10 R-type (use funct), 11 reserved.
REQ-008 funct  input  6  R-type function select.
REQ-009 src_a  input  WIDTH  operand A.
REQ-010 src_b  input  WIDTH  operand B.
REQ-011 out_valid  output  1  result/zero/err valid.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 result  output  WIDTH  registered result.
REQ-014 zero  output  1  high when result equals 0; combinational from result register.
REQ-015 err  output  1  registered; high when request was illegal.

Function
REQ-016 States: IDLE, MUL, HOLD; handshake occurs when in_valid && in_ready.
REQ-017 in_ready SHALL be high in IDLE, or in HOLD when out_ready is high; low in MUL.
REQ-018 Decode: alu_op 00 add; 01 A-B; 11 add with err=1; 10 per funct: 000000 add, 000001 sub, 000010 signed slt (result 1 or 0), 000011 and, 000100 or, 000101 xor, 000110 nor, 000111 mul.
REQ-019 Undecoded funct under alu_op 10 SHALL give result 0, err=1, latency as a single-cycle op.
REQ-020 Add/sub wrap modulo 2^WIDTH; no overflow flag.
REQ-021 Single-cycle op: result/err registered at accept edge; out_valid high the following cycle (latency 1); next state HOLD.
REQ-022 mul: unsigned shift-add, one multiplier bit per cycle, exactly WIDTH cycles in MUL, result = low WIDTH bits of A*B; out_valid rises WIDTH+1 cycles after accept.
REQ-023 HOLD: out_valid high; result/zero/err stable until out_ready high.
REQ-024 HOLD with out_ready high and no accept: next state IDLE, out_valid low next cycle.
REQ-025 HOLD with out_ready and accept in same cycle: new request decoded; back-to-back single-cycle ops give one result per cycle.
REQ-026 in_valid in MUL ignored; operands captured at accept, later input changes have no effect.
REQ-027 err cleared on every accepted legal request.

Reset
REQ-028 rst high at a rising edge: state IDLE, out_valid 0, result 0 (zero 1), err 0, step counter 0, multiplier shadow registers 0.
REQ-029 rst overrides in-progress MUL or HOLD; pending result discarded, no out_valid pulse.
REQ-030 in_ready SHALL be low while rst is high.

Configuration
REQ-031 Macro ALU_EXEC_MUL_EN defined: funct 000111 executes multiply per REQ-022, MUL state present.
REQ-032 ALU_EXEC_MUL_EN undefined: MUL state and multiply registers absent; funct 000111 treated as undecoded per REQ-019.

Verification (WIDTH=32)
REQ-033 Reset then alu_op 00, A=5, B=7 -> next cycle out_valid=1, result=12, zero=0, err=0.
REQ-034 alu_op 01, A=9, B=9 -> result=0, zero=1; alu_op 10 funct 000010, A=0xFFFFFFFF, B=1 -> result=1.
REQ-035 out_ready tied high, four back-to-back requests (add 1+1, sub 3-5, and 0xF0&0x3C, nor 0,0) -> results 2, 0xFFFFFFFE, 0x30, 0xFFFFFFFF on four consecutive cycles.
REQ-036 With ALU_EXEC_MUL_EN: mul A=0x10001, B=0x10001 -> in_ready low 32 cycles, out_valid at cycle 33, result=0x00020001; without macro -> result 0, err=1 at cycle 1.
REQ-037 out_ready low 5 cycles in HOLD -> result stable, in_ready low; funct 111111 -> err=1, result 0.
REQ-038 rst asserted at cycle 10 of a mul -> out_valid never asserts, in_ready high cycle after rst deasserts, result 0.
